// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: arbitrates interrupt/exception/ERET, writes CP0 for one cycle, then flushes and redirects.
module cp0_exc_ctrl #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [WIDTH-1:0] mem_pc,
  input  logic             mem_bd,
  input  logic             exc_valid,
  input  logic [4:0]       exc_code,
  input  logic             exc_has_badvaddr,
  input  logic [WIDTH-1:0] exc_badvaddr,
  input  logic             eret_valid,
  input  logic [5:0]       hw_int,
  input  logic [WIDTH-1:0] status_in,
  input  logic [WIDTH-1:0] cause_in,
  input  logic [WIDTH-1:0] epc_in,
  output logic [WIDTH-1:0] cp0_we,
  output logic [WIDTH-1:0] cp0_epc,
  output logic [WIDTH-1:0] cp0_badaddr,
  output logic             cp0_exl,
  output logic             cp0_bd,
  output logic [4:0]       cp0_exc_code,
  output logic [5:0]       cp0_hw_int,
  output logic             busy,
  output logic             flush,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, WRITE, REDIRECT} state_t;
  state_t state_q, state_d;
  logic [5:0] hw_s1_q, hw_s2_q;
  logic [WIDTH-1:0] pc_q, pc_d, bad_q, bad_d, target_q, target_d;
  logic bd_q, bd_d, has_bad_q, has_bad_d, eret_q, eret_d;
  logic [4:0] code_q, code_d;
  logic int_pending, take_int, take_exc, take_eret, idle, wr, rd, ex;
  logic unused;
  assign unused = ^{status_in[WIDTH-1:16], status_in[7:2], cause_in[WIDTH-1:10], cause_in[7:0]};
  assign int_pending = status_in[0] & ~status_in[1] & |({hw_s2_q, cause_in[9:8]} & status_in[15:8]);
  always_comb begin
    idle      = state_q == IDLE;
    take_int  = mem_valid & int_pending;
    take_exc  = mem_valid & exc_valid & ~int_pending;
    take_eret = mem_valid & eret_valid & ~exc_valid & ~int_pending;
    state_d   = idle ? ((take_int | take_exc | take_eret) ? WRITE : IDLE) :
                state_q == WRITE ? REDIRECT : IDLE;
    // latches load every idle cycle; only the value captured on the leaving edge matters
    pc_d      = idle ? mem_pc : pc_q;
    bd_d      = idle ? mem_bd : bd_q;
    code_d    = idle ? (take_exc ? exc_code : 5'd0) : code_q;
    has_bad_d = idle ? take_exc & exc_has_badvaddr : has_bad_q;
    bad_d     = idle ? (take_exc & exc_has_badvaddr ? exc_badvaddr : '0) : bad_q;
    eret_d    = idle ? take_eret : eret_q;
    target_d  = idle ? epc_in : target_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hw_s1_q   <= '0;
      hw_s2_q   <= '0;
      pc_q      <= '0;
      bd_q      <= 1'b0;
      code_q    <= '0;
      has_bad_q <= 1'b0;
      bad_q     <= '0;
      eret_q    <= 1'b0;
      target_q  <= '0;
    end else begin
      state_q   <= state_d;
      hw_s1_q   <= hw_int;
      hw_s2_q   <= hw_s1_q;
      pc_q      <= pc_d;
      bd_q      <= bd_d;
      code_q    <= code_d;
      has_bad_q <= has_bad_d;
      bad_q     <= bad_d;
      eret_q    <= eret_d;
      target_q  <= target_d;
    end
  end
  assign wr = state_q == WRITE;
  assign rd = state_q == REDIRECT;
  assign ex = wr & ~eret_q;
  assign cp0_we         = WIDTH'({ex, ex, wr, 3'b000, ex & has_bad_q, 8'h00});
  assign cp0_epc        = ex ? (bd_q ? pc_q - WIDTH'(4) : pc_q) : '0;
  assign cp0_badaddr    = ex ? bad_q : '0;
  assign cp0_exl        = ex;
  assign cp0_bd         = ex & bd_q;
  assign cp0_exc_code   = ex ? code_q : 5'd0;
  assign cp0_hw_int     = hw_s2_q;
  assign busy           = wr | rd;
  assign flush          = rd;
  assign redirect_valid = rd;
  assign redirect_pc    = rd ? (eret_q ? target_q : EXC_VECTOR) : '0;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: table-driven directed test of the CP0 exception sequencer.
module tb_cp0_exc_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_valid, mem_bd, exc_valid, exc_has_badvaddr, eret_valid;
  logic [31:0] mem_pc, exc_badvaddr, status_in, cause_in, epc_in;
  logic [4:0] exc_code;
  logic [5:0] hw_int;
  logic [31:0] cp0_we, cp0_epc, cp0_badaddr, redirect_pc;
  logic cp0_exl, cp0_bd, busy, flush, redirect_valid;
  logic [4:0] cp0_exc_code;
  logic [5:0] cp0_hw_int;
  int total = 0, bad = 0;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_bd(mem_bd),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_has_badvaddr(exc_has_badvaddr),
    .exc_badvaddr(exc_badvaddr), .eret_valid(eret_valid), .hw_int(hw_int),
    .status_in(status_in), .cause_in(cause_in), .epc_in(epc_in), .cp0_we(cp0_we),
    .cp0_epc(cp0_epc), .cp0_badaddr(cp0_badaddr), .cp0_exl(cp0_exl), .cp0_bd(cp0_bd),
    .cp0_exc_code(cp0_exc_code), .cp0_hw_int(cp0_hw_int), .busy(busy), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mv; logic [31:0] pc; logic bd; logic ev; logic [4:0] code; logic hb;
    logic [31:0] bv; logic er; logic [5:0] hw; logic [31:0] st, ca, epc;
    logic take; logic [31:0] we, xepc, xbad; logic xexl, xbd; logic [4:0] xcode; logic [31:0] rpc;
  } vec_t;
  vec_t v[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    mem_valid = 1'b0; mem_pc = '0; mem_bd = 1'b0; exc_valid = 1'b0; exc_code = '0;
    exc_has_badvaddr = 1'b0; exc_badvaddr = '0; eret_valid = 1'b0; hw_int = '0;
    status_in = '0; cause_in = '0; epc_in = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0]  = '{1'b1, 32'h80001000, 1'b0, 1'b1, 5'h0A, 1'b0, 32'h0,    1'b0, 6'h00, 32'h0,   32'h0,   32'h0,
              1'b1, 32'h7000, 32'h80001000, 32'h0,    1'b1, 1'b0, 5'h0A, 32'hBFC00380};
    v[1]  = '{1'b1, 32'h80002004, 1'b1, 1'b1, 5'h04, 1'b1, 32'h1233, 1'b0, 6'h00, 32'h0,   32'h0,   32'h0,
              1'b1, 32'h7100, 32'h80002000, 32'h1233, 1'b1, 1'b1, 5'h04, 32'hBFC00380};
    v[2]  = '{1'b1, 32'h80004000, 1'b0, 1'b1, 5'h0A, 1'b1, 32'hDEAD, 1'b0, 6'h01, 32'h401, 32'h0,   32'h0,
              1'b1, 32'h7000, 32'h80004000, 32'h0,    1'b1, 1'b0, 5'h00, 32'hBFC00380};
    v[3]  = '{1'b1, 32'h80005000, 1'b0, 1'b1, 5'h0C, 1'b0, 32'h0,    1'b0, 6'h01, 32'h403, 32'h0,   32'h0,
              1'b1, 32'h7000, 32'h80005000, 32'h0,    1'b1, 1'b0, 5'h0C, 32'hBFC00380};
    v[4]  = '{1'b1, 32'h80003008, 1'b0, 1'b0, 5'h00, 1'b0, 32'h0,    1'b1, 6'h00, 32'h2,   32'h0,   32'h80003000,
              1'b1, 32'h1000, 32'h0,        32'h0,    1'b0, 1'b0, 5'h00, 32'h80003000};
    v[5]  = '{1'b1, 32'h80006000, 1'b0, 1'b1, 5'h08, 1'b0, 32'h0,    1'b1, 6'h00, 32'h2,   32'h0,   32'h80003000,
              1'b1, 32'h7000, 32'h80006000, 32'h0,    1'b1, 1'b0, 5'h08, 32'hBFC00380};
    v[6]  = '{1'b1, 32'h80007000, 1'b1, 1'b0, 5'h00, 1'b0, 32'h0,    1'b1, 6'h00, 32'h0,   32'h0,   32'h80007010,
              1'b1, 32'h1000, 32'h0,        32'h0,    1'b0, 1'b0, 5'h00, 32'h80007010};
    v[7]  = '{1'b0, 32'h80009000, 1'b0, 1'b1, 5'h0A, 1'b0, 32'h0,    1'b1, 6'h01, 32'h401, 32'h0,   32'h0,
              1'b0, 32'h0,    32'h0,        32'h0,    1'b0, 1'b0, 5'h00, 32'h0};
    v[8]  = '{1'b1, 32'h80008008, 1'b1, 1'b0, 5'h00, 1'b0, 32'h0,    1'b0, 6'h00, 32'h101, 32'h100, 32'h0,
              1'b1, 32'h7000, 32'h80008004, 32'h0,    1'b1, 1'b1, 5'h00, 32'hBFC00380};
    v[9]  = '{1'b1, 32'h8000A000, 1'b0, 1'b0, 5'h00, 1'b0, 32'h0,    1'b0, 6'h01, 32'h400, 32'h0,   32'h0,
              1'b0, 32'h0,    32'h0,        32'h0,    1'b0, 1'b0, 5'h00, 32'h0};
    v[10] = '{1'b1, 32'h00000000, 1'b1, 1'b1, 5'h0D, 1'b0, 32'h0,    1'b0, 6'h00, 32'h0,   32'h0,   32'h0,
              1'b1, 32'h7000, 32'hFFFFFFFC, 32'h0,    1'b1, 1'b1, 5'h0D, 32'hBFC00380};
    v[11] = '{1'b1, 32'h8000B000, 1'b0, 1'b0, 5'h00, 1'b0, 32'h0,    1'b0, 6'h00, 32'h401, 32'h0,   32'h0,
              1'b0, 32'h0,    32'h0,        32'h0,    1'b0, 1'b0, 5'h00, 32'h0};
    v[12] = '{1'b1, 32'h8000C000, 1'b0, 1'b1, 5'h05, 1'b1, 32'h44,   1'b0, 6'h02, 32'h401, 32'h0,   32'h0,
              1'b1, 32'h7100, 32'h8000C000, 32'h44,   1'b1, 1'b0, 5'h05, 32'hBFC00380};
    v[13] = '{1'b1, 32'h8000D004, 1'b1, 1'b0, 5'h00, 1'b0, 32'h0,    1'b0, 6'h20, 32'h8001, 32'h0,  32'h0,
              1'b1, 32'h7000, 32'h8000D000, 32'h0,    1'b1, 1'b1, 5'h00, 32'hBFC00380};
    clear_in();
    hw_int = 6'h3F;
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_we", cp0_we, 32'h0);
    chk("rst_flush", {30'b0, flush, redirect_valid}, 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_hwint", {26'b0, cp0_hw_int}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      clear_in();
      hw_int = v[i].hw; status_in = v[i].st; cause_in = v[i].ca; epc_in = v[i].epc;
      mem_pc = v[i].pc; mem_bd = v[i].bd; exc_valid = v[i].ev; exc_code = v[i].code;
      exc_has_badvaddr = v[i].hb; exc_badvaddr = v[i].bv; eret_valid = v[i].er;
      tick();
      tick();
      chk($sformatf("v%0d_settle_busy", i), {31'b0, busy}, 32'h0);
      chk($sformatf("v%0d_hwint", i), {26'b0, cp0_hw_int}, {26'b0, v[i].hw});
      mem_valid = v[i].mv;
      tick();
      clear_in();
      hw_int = v[i].hw;
      if (v[i].take) begin
        chk($sformatf("v%0d_we", i), cp0_we, v[i].we);
        chk($sformatf("v%0d_epc", i), cp0_epc, v[i].xepc);
        chk($sformatf("v%0d_bad", i), cp0_badaddr, v[i].xbad);
        chk($sformatf("v%0d_exl_bd", i), {30'b0, cp0_exl, cp0_bd}, {30'b0, v[i].xexl, v[i].xbd});
        chk($sformatf("v%0d_code", i), {27'b0, cp0_exc_code}, {27'b0, v[i].xcode});
        chk($sformatf("v%0d_wr_busy_flush", i), {30'b0, busy, flush}, 32'h2);
        tick();
        chk($sformatf("v%0d_rd_flush_rv", i), {29'b0, busy, flush, redirect_valid}, 32'h7);
        chk($sformatf("v%0d_rpc", i), redirect_pc, v[i].rpc);
        chk($sformatf("v%0d_rd_we", i), cp0_we, 32'h0);
        tick();
        chk($sformatf("v%0d_done_busy", i), {30'b0, busy, flush}, 32'h0);
      end else begin
        chk($sformatf("v%0d_notake", i), {29'b0, busy, flush, redirect_valid}, 32'h0);
        chk($sformatf("v%0d_notake_we", i), cp0_we, 32'h0);
      end
    end
    clear_in();
    mem_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'h0A; mem_pc = 32'h80001000;
    tick();
    chk("b2b_e1_we", cp0_we, 32'h7000);
    tick();
    chk("b2b_e2_flush", {31'b0, flush}, 32'h1);
    tick();
    chk("b2b_e3_busy", {31'b0, busy}, 32'h0);
    tick();
    chk("b2b_e4_we", cp0_we, 32'h7000);
    clear_in();
    tick();
    tick();
    chk("b2b_idle", {31'b0, busy}, 32'h0);
    mem_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'h04; exc_has_badvaddr = 1'b1;
    exc_badvaddr = 32'h55; mem_pc = 32'h80002000;
    tick();
    clear_in();
    chk("rstw_busy_pre", {31'b0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_busy", {31'b0, busy}, 32'h0);
    chk("rstw_we", cp0_we, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstw_noredir", {30'b0, flush, redirect_valid}, 32'h0);
    tick();
    chk("rstw_idle", {31'b0, busy}, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
